// File: rtl/mem_array_rf_pkg.sv
// Shared types and defaults for the mem_array_rf register-file memory.
// Holds the FSM state encoding, default parameters and the address-width helper.
package mem_array_rf_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_DEPTH     = 3;
    localparam int DEF_NUM_RD    = 2;
    localparam int DEF_WR_BYPASS = 1;

    // Address width for a given depth, never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_array_rd_port.sv
// One registered read channel: range check, same-cycle write bypass and
// output registers for valid, data and error.
module mem_array_rd_port #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 3,
    parameter int AW        = 2,
    parameter int WR_BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             wr_we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_err
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             oor;
    logic             bypass_hit;

    assign oor        = ({1'b0, rd_addr} >= DEPTH_W);
    assign bypass_hit = (WR_BYPASS != 0) && wr_we && (wr_addr == rd_addr);

    // NOTE: every always_comb output is given a default first so no latch is inferred.
    always_comb begin
        valid_d = rd_en;
        err_d   = err_q;
        data_d  = data_q;
        if (rd_en) begin
            err_d = oor;
            if (oor) begin
                data_d = '0;
            end else if (bypass_hit) begin
                data_d = wr_data;
            end else begin
                data_d = mem_rdata;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign rd_valid = valid_q;
    assign rd_data  = data_q;
    assign rd_err   = err_q;

endmodule

// File: rtl/mem_array_rf.sv
// WIDTH x DEPTH register-file memory with one write port, NUM_RD registered
// read channels and a post-reset sweep that loads INIT_VALUE into every entry.
module mem_array_rf
    import mem_array_rf_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter int               DEPTH      = DEF_DEPTH,
    parameter int               NUM_RD     = DEF_NUM_RD,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0,
    parameter int               WR_BYPASS  = DEF_WR_BYPASS,
    localparam int              AW         = addr_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    output logic                    wr_err,
    input  logic [NUM_RD-1:0]       rd_req,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD-1:0]       rd_valid,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_err,
    output logic                    init_done
);

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             wr_err_q, wr_err_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             wr_fire;
    logic             wr_in_range;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    assign wr_ready    = (state_q == ST_RUN);
    assign init_done   = (state_q == ST_RUN);
    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    assign wr_err      = wr_err_q;

    // The sweep and user writes share the single array write port.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        wr_err_d  = wr_fire && !wr_in_range;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = INIT_VALUE;
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_RUN;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_RUN: begin
                mem_we = wr_fire && wr_in_range;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_INIT;
            ptr_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            wr_err_q <= wr_err_d;
        end
    end

    // NOTE: the array has no reset; the init sweep is what gives it defined contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            logic [AW-1:0]    addr_k;
            logic [WIDTH-1:0] mem_rdata_k;

            assign addr_k      = rd_addr[k*AW +: AW];
            assign mem_rdata_k = mem_q[addr_k];

            mem_array_rd_port #(
                .WIDTH     (WIDTH),
                .DEPTH     (DEPTH),
                .AW        (AW),
                .WR_BYPASS (WR_BYPASS)
            ) u_rd_port (
                .clk       (clk),
                .rst       (rst),
                .rd_en     (rd_req[k] && wr_ready),
                .rd_addr   (addr_k),
                .mem_rdata (mem_rdata_k),
                .wr_we     (mem_we),
                .wr_addr   (mem_waddr),
                .wr_data   (mem_wdata),
                .rd_valid  (rd_valid[k]),
                .rd_data   (rd_data[k*WIDTH +: WIDTH]),
                .rd_err    (rd_err[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_mem_array_rf.sv
// Bench for mem_array_rf: build A (DEPTH=3, bypass) and build B (DEPTH=8, no bypass)
// checked every cycle against a spec-level model plus directed literal expectations.
module tb_mem_array_rf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0 drives build A, index 1 drives build B.
    logic       rst_s      [2];
    logic       wr_valid_s [2];
    logic [2:0] wr_addr_s  [2];
    logic [3:0] wr_data_s  [2];
    logic [1:0] rd_req_s   [2];
    logic [2:0] ra0        [2];
    logic [2:0] ra1        [2];

    logic       o_wr_ready  [2];
    logic       o_wr_err    [2];
    logic       o_init_done [2];
    logic [1:0] o_rd_valid  [2];
    logic [1:0] o_rd_err    [2];
    logic [7:0] o_rd_data   [2];

    int n_cmp = 0;
    int n_bad = 0;

    mem_array_rf #(
        .WIDTH(4), .DEPTH(3), .NUM_RD(2), .INIT_VALUE(4'h0), .WR_BYPASS(1)
    ) u_dut_a (
        .clk       (clk),
        .rst       (rst_s[0]),
        .wr_valid  (wr_valid_s[0]),
        .wr_ready  (o_wr_ready[0]),
        .wr_addr   (wr_addr_s[0][1:0]),
        .wr_data   (wr_data_s[0]),
        .wr_err    (o_wr_err[0]),
        .rd_req    (rd_req_s[0]),
        .rd_addr   ({ra1[0][1:0], ra0[0][1:0]}),
        .rd_valid  (o_rd_valid[0]),
        .rd_data   (o_rd_data[0]),
        .rd_err    (o_rd_err[0]),
        .init_done (o_init_done[0])
    );

    mem_array_rf #(
        .WIDTH(4), .DEPTH(8), .NUM_RD(2), .INIT_VALUE(4'h0), .WR_BYPASS(0)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst_s[1]),
        .wr_valid  (wr_valid_s[1]),
        .wr_ready  (o_wr_ready[1]),
        .wr_addr   (wr_addr_s[1]),
        .wr_data   (wr_data_s[1]),
        .wr_err    (o_wr_err[1]),
        .rd_req    (rd_req_s[1]),
        .rd_addr   ({ra1[1], ra0[1]}),
        .rd_valid  (o_rd_valid[1]),
        .rd_data   (o_rd_data[1]),
        .rd_err    (o_rd_err[1]),
        .init_done (o_init_done[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int depth_of(input int i);
        return (i == 0) ? 3 : 8;
    endfunction

    function automatic bit bypass_of(input int i);
        return (i == 0);
    endfunction

    // ---------------- behavioural model ----------------
    int         cnt      [2];
    logic [3:0] mem_m    [2][8];
    logic [1:0] e_valid  [2];
    logic [1:0] e_err    [2];
    logic [7:0] e_data   [2];
    logic       e_wr_err [2];
    bit         armed    [2];

    // cnt = clean cycles since reset; the memory is usable once DEPTH of them elapsed.
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                int         d;
                bit         rdy;
                logic [2:0] a;
                d = depth_of(i);
                if (rst_s[i]) begin
                    cnt[i]      = 0;
                    e_valid[i]  = 2'b00;
                    e_err[i]    = 2'b00;
                    e_data[i]   = 8'h00;
                    e_wr_err[i] = 1'b0;
                    armed[i]    = 1'b1;
                end else begin
                    rdy = (cnt[i] >= d);
                    for (int k = 0; k < 2; k++) begin
                        a = (k == 0) ? ra0[i] : ra1[i];
                        if (rdy && rd_req_s[i][k]) begin
                            e_valid[i][k] = 1'b1;
                            if (a >= d) begin
                                e_err[i][k]        = 1'b1;
                                e_data[i][k*4 +: 4] = 4'h0;
                            end else begin
                                e_err[i][k] = 1'b0;
                                if (bypass_of(i) && wr_valid_s[i] && (wr_addr_s[i] == a))
                                    e_data[i][k*4 +: 4] = wr_data_s[i];
                                else
                                    e_data[i][k*4 +: 4] = mem_m[i][a];
                            end
                        end else begin
                            e_valid[i][k] = 1'b0;
                        end
                    end
                    e_wr_err[i] = rdy && wr_valid_s[i] && (wr_addr_s[i] >= d);
                    if (rdy && wr_valid_s[i] && (wr_addr_s[i] < d))
                        mem_m[i][wr_addr_s[i]] = wr_data_s[i];
                    if (!rdy)
                        mem_m[i][cnt[i]] = 4'h0;
                    if (cnt[i] < d)
                        cnt[i]++;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (armed[i]) begin
                    string p;
                    p = (i == 0) ? "a" : "b";
                    check({p, "_wr_ready"},  o_wr_ready[i],  cnt[i] >= depth_of(i));
                    check({p, "_init_done"}, o_init_done[i], cnt[i] >= depth_of(i));
                    check({p, "_wr_err"},    o_wr_err[i],    e_wr_err[i]);
                    check({p, "_rd_valid"},  o_rd_valid[i],  e_valid[i]);
                    check({p, "_rd_data"},   o_rd_data[i],   e_data[i]);
                    check({p, "_rd_err"},    o_rd_err[i] & e_valid[i], e_err[i] & e_valid[i]);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int i = 0; i < 2; i++) begin
            wr_valid_s[i] = 1'b0;
            wr_addr_s[i]  = 3'd0;
            wr_data_s[i]  = 4'h0;
            rd_req_s[i]   = 2'b00;
            ra0[i]        = 3'd0;
            ra1[i]        = 3'd0;
        end
    endtask

    initial begin
        idle();
        rst_s[0] = 1'b1;
        rst_s[1] = 1'b1;
        step();
        step();
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;

        // Init sweep length: A ready after 3 cycles, B after 8.
        for (int n = 1; n <= 9; n++) begin
            step();
            check("a_init_done_t", o_init_done[0], n >= 3);
            check("a_wr_ready_t",  o_wr_ready[0],  n >= 3);
            check("b_init_done_t", o_init_done[1], n >= 8);
        end

        // A: every entry holds INIT_VALUE on both channels.
        for (int a = 0; a < 3; a++) begin
            rd_req_s[0] = 2'b11;
            ra0[0] = 3'(a);
            ra1[0] = 3'(a);
            step();
            idle();
            check("a_init_rd_valid", o_rd_valid[0], 2'b11);
            check("a_init_rd_data",  o_rd_data[0],  8'h00);
        end

        // A: write 0xA to addr 1, then read it back.
        wr_valid_s[0] = 1'b1; wr_addr_s[0] = 3'd1; wr_data_s[0] = 4'hA;
        step();
        idle();
        rd_req_s[0] = 2'b01; ra0[0] = 3'd1;
        step();
        idle();
        check("a_lat_valid", o_rd_valid[0][0],  1'b1);
        check("a_lat_data",  o_rd_data[0][3:0], 4'hA);
        check("a_lat_err",   o_rd_err[0][0],    1'b0);

        // Same-cycle write 0x5 and read of addr 2 on both builds.
        for (int i = 0; i < 2; i++) begin
            wr_valid_s[i] = 1'b1; wr_addr_s[i] = 3'd2; wr_data_s[i] = 4'h5;
            rd_req_s[i] = 2'b01; ra0[i] = 3'd2;
        end
        step();
        idle();
        check("a_bypass_data", o_rd_data[0][3:0], 4'h5);
        check("b_nobyp_data",  o_rd_data[1][3:0], 4'h0);

        // A: out-of-range write pulses wr_err once and leaves the array alone.
        wr_valid_s[0] = 1'b1; wr_addr_s[0] = 3'd3; wr_data_s[0] = 4'hF;
        step();
        idle();
        check("a_wr_err_pulse", o_wr_err[0], 1'b1);
        step();
        check("a_wr_err_clear", o_wr_err[0], 1'b0);
        rd_req_s[0] = 2'b11; ra0[0] = 3'd3; ra1[0] = 3'd2;
        step();
        idle();
        check("a_oor_valid", o_rd_valid[0], 2'b11);
        check("a_oor_err",   o_rd_err[0],   2'b01);
        check("a_oor_data",  o_rd_data[0],  8'h50);

        // A: independent and shared addresses across channels.
        rd_req_s[0] = 2'b11; ra0[0] = 3'd0; ra1[0] = 3'd1;
        step();
        idle();
        check("a_multi_data", o_rd_data[0], 8'hA0);
        rd_req_s[0] = 2'b11; ra0[0] = 3'd1; ra1[0] = 3'd1;
        step();
        idle();
        check("a_same_data", o_rd_data[0], 8'hAA);

        // B: write addr 5, then reset during a read; the read is dropped.
        wr_valid_s[1] = 1'b1; wr_addr_s[1] = 3'd5; wr_data_s[1] = 4'h9;
        step();
        idle();
        rst_s[1] = 1'b1;
        rd_req_s[1] = 2'b11; ra0[1] = 3'd5; ra1[1] = 3'd5;
        step();
        idle();
        rst_s[1] = 1'b0;
        check("b_rst_rd_valid", o_rd_valid[1], 2'b00);

        // B: four sweep cycles with a write held (ignored), then reset at sweep cycle 4.
        for (int n = 0; n < 4; n++) begin
            wr_valid_s[1] = 1'b1; wr_addr_s[1] = 3'd7; wr_data_s[1] = 4'hC;
            step();
            check("b_sweep_wr_ready", o_wr_ready[1], 1'b0);
        end
        idle();
        rst_s[1] = 1'b1;
        step();
        rst_s[1] = 1'b0;
        check("b_midrst_done", o_init_done[1], 1'b0);
        for (int n = 1; n <= 9; n++) begin
            step();
            check("b_resweep_done", o_init_done[1], n >= 8);
        end
        rd_req_s[1] = 2'b11; ra0[1] = 3'd5; ra1[1] = 3'd7;
        step();
        idle();
        check("b_resweep_valid", o_rd_valid[1], 2'b11);
        check("b_resweep_data",  o_rd_data[1],  8'h00);

        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
